// File: rtl/matrix_frame_rx.sv
// Byte-stream receiver for small matrices: 0xA5, rows, cols, row-major elements
// (MSB-first), XOR checksum. A good frame is published on matrix_flat with a pulse.
module matrix_frame_rx #(
  parameter int MAX_DIM     = 5,
  parameter int ELEM_W      = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 enable,
  input  logic [7:0]                           byte_in,
  input  logic                                 byte_valid,
  output logic [2:0]                           rows,
  output logic [2:0]                           cols,
  output logic [MAX_DIM*MAX_DIM*ELEM_W-1:0]    matrix_flat,
  output logic                                 frame_valid,
  output logic                                 busy,
  output logic                                 err,
  output logic [1:0]                           err_code,
  output logic [7:0]                           frame_cnt
);

  localparam int EB   = ELEM_W / 8;
  localparam int NEL  = MAX_DIM * MAX_DIM;
  localparam int MW   = NEL * ELEM_W;
  localparam int BCW  = (EB > 1) ? $clog2(EB) : 1;
  localparam int IW   = (NEL > 1) ? $clog2(NEL) : 1;
  localparam logic [31:0] TLIM = 32'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {IDLE, ROWS, COLS, DATA, CSUM} state_t;

  state_t            state, state_next;
  logic [7:0]        rows_lat, cols_lat, csum;
  logic [2:0]        cur_r, cur_c;
  logic [BCW-1:0]    byte_cnt;
  logic [ELEM_W-1:0] elem_acc, elem_next;
  logic [ELEM_W+7:0] elem_shift;
  logic [MW-1:0]     shadow;
  logic [31:0]       tcnt;
  logic [IW-1:0]     elem_idx;

  logic take, tout, dim_bad, last_byte, last_elem, last_col;
  logic start_frame, take_rows, take_cols, take_data, csum_ok, csum_bad, dim_err;

  assign take       = enable & byte_valid;
  assign busy       = (state != IDLE);
  assign tout       = enable & busy & ~byte_valid & (tcnt == TLIM);
  assign dim_bad    = (rows_lat == 8'd0) || (rows_lat > 8'(MAX_DIM)) ||
                      (byte_in == 8'd0)  || (byte_in > 8'(MAX_DIM));
  assign last_byte  = (byte_cnt == BCW'(EB - 1));
  assign last_col   = (cur_c == cols_lat[2:0] - 3'd1);
  assign last_elem  = last_col && (cur_r == rows_lat[2:0] - 3'd1);
  // Shifting the new byte in from the right and keeping the low ELEM_W bits
  // gives MSB-first assembly for either element width.
  assign elem_shift = {elem_acc, byte_in};
  assign elem_next  = elem_shift[ELEM_W-1:0];
  assign elem_idx   = IW'(32'(cur_r) * MAX_DIM + 32'(cur_c));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // A byte arriving in the expiry cycle suppresses tout, so it always wins.
  always_comb begin
    state_next  = state;
    start_frame = 1'b0;
    take_rows   = 1'b0;
    take_cols   = 1'b0;
    take_data   = 1'b0;
    csum_ok     = 1'b0;
    csum_bad    = 1'b0;
    dim_err     = 1'b0;
    if (!enable || tout) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: if (take && byte_in == 8'hA5) begin
          start_frame = 1'b1;
          state_next  = ROWS;
        end
        ROWS: if (take) begin
          take_rows  = 1'b1;
          state_next = COLS;
        end
        COLS: if (take) begin
          take_cols = 1'b1;
          if (dim_bad) begin
            dim_err    = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = DATA;
          end
        end
        DATA: if (take) begin
          take_data = 1'b1;
          if (last_byte && last_elem) state_next = CSUM;
        end
        CSUM: if (take) begin
          if (byte_in == csum) csum_ok  = 1'b1;
          else                 csum_bad = 1'b1;
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Frame assembly happens in the shadow buffer; visible outputs only change
  // when the checksum matches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rows_lat    <= '0;
      cols_lat    <= '0;
      csum        <= '0;
      cur_r       <= '0;
      cur_c       <= '0;
      byte_cnt    <= '0;
      elem_acc    <= '0;
      shadow      <= '0;
      tcnt        <= '0;
      rows        <= '0;
      cols        <= '0;
      matrix_flat <= '0;
      frame_valid <= 1'b0;
      err         <= 1'b0;
      err_code    <= '0;
      frame_cnt   <= '0;
    end else begin
      frame_valid <= 1'b0;
      err         <= 1'b0;

      if (state_next == IDLE || byte_valid) tcnt <= '0;
      else                                  tcnt <= tcnt + 32'd1;

      if (start_frame) begin
        shadow   <= '0;
        csum     <= '0;
        cur_r    <= '0;
        cur_c    <= '0;
        byte_cnt <= '0;
        elem_acc <= '0;
      end

      if (take_rows) begin
        rows_lat <= byte_in;
        csum     <= csum ^ byte_in;
      end

      if (take_cols) begin
        cols_lat <= byte_in;
        csum     <= csum ^ byte_in;
      end

      if (take_data) begin
        csum <= csum ^ byte_in;
        if (last_byte) begin
          shadow[elem_idx*ELEM_W +: ELEM_W] <= elem_next;
          byte_cnt <= '0;
          elem_acc <= '0;
          if (last_col) begin
            cur_c <= '0;
            cur_r <= cur_r + 3'd1;
          end else begin
            cur_c <= cur_c + 3'd1;
          end
        end else begin
          byte_cnt <= byte_cnt + 1'b1;
          elem_acc <= elem_next;
        end
      end

      if (csum_ok) begin
        matrix_flat <= shadow;
        rows        <= rows_lat[2:0];
        cols        <= cols_lat[2:0];
        frame_cnt   <= frame_cnt + 8'd1;
        frame_valid <= 1'b1;
      end

      if (csum_bad) begin
        err      <= 1'b1;
        err_code <= 2'd2;
      end

      if (dim_err) begin
        err      <= 1'b1;
        err_code <= 2'd1;
      end

      if (tout) begin
        err      <= 1'b1;
        err_code <= 2'd3;
      end
    end
  end

endmodule

// File: tb/tb_matrix_frame_rx.sv
// Randomized frame stream for matrix_frame_rx checked against a frame-level model,
// plus directed frames for errors, timeout, enable, reset and 16-bit elements.
module tb_matrix_frame_rx;

  localparam int MAX_DIM = 5;
  localparam int TO      = 100;
  localparam int MW      = MAX_DIM * MAX_DIM * 8;
  localparam int MW16    = MAX_DIM * MAX_DIM * 16;

  logic          clk = 1'b0;
  logic          rst, enable, byte_valid, byte_valid16;
  logic [7:0]    byte_in, byte_in16;
  logic [2:0]    rows, cols, rows16, cols16;
  logic [MW-1:0] matrix_flat;
  logic [MW16-1:0] matrix16;
  logic          frame_valid, busy, err, fv16, busy16, err16;
  logic [1:0]    err_code, err_code16;
  logic [7:0]    frame_cnt, frame_cnt16;

  matrix_frame_rx #(.MAX_DIM(MAX_DIM), .ELEM_W(8), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .enable(enable), .byte_in(byte_in), .byte_valid(byte_valid),
    .rows(rows), .cols(cols), .matrix_flat(matrix_flat), .frame_valid(frame_valid),
    .busy(busy), .err(err), .err_code(err_code), .frame_cnt(frame_cnt));

  matrix_frame_rx #(.MAX_DIM(MAX_DIM), .ELEM_W(16), .TIMEOUT_CYC(TO)) dut16 (
    .clk(clk), .rst(rst), .enable(enable), .byte_in(byte_in16), .byte_valid(byte_valid16),
    .rows(rows16), .cols(cols16), .matrix_flat(matrix16), .frame_valid(fv16),
    .busy(busy16), .err(err16), .err_code(err_code16), .frame_cnt(frame_cnt16));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int fvCount = 0, errCount = 0;
  logic [MW-1:0] fvMatrix = '0;

  logic [MW-1:0] expMatrix;
  int expRows, expCols, expCnt, expFv, expErr, expCode;
  logic [7:0] txQ[$];
  logic [7:0] presetQ[$];

  // Pulse monitor; the matrix is snapshotted while frame_valid is high.
  always @(negedge clk) begin
    if (frame_valid) begin
      fvCount++;
      fvMatrix = matrix_flat;
    end
    if (err) errCount++;
  end

  task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sendByte(input logic [7:0] b);
    byte_in    = b;
    byte_valid = 1'b1;
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
  endtask

  task automatic sendByte16(input logic [7:0] b);
    byte_in16    = b;
    byte_valid16 = 1'b1;
    @(posedge clk);
    #1;
    byte_valid16 = 1'b0;
  endtask

  task automatic applyStimulus(input int maxGap);
    while (txQ.size() > 0) begin
      sendByte(txQ.pop_front());
      idleCycles($urandom_range(0, maxGap));
    end
  endtask

  // Frame model: element k of an r x c frame lands at index (k/c)*MAX_DIM + k%c.
  task automatic queueGood(input int r, input int c, input bit corrupt);
    logic [7:0]    cs, e;
    logic [MW-1:0] m;
    m  = '0;
    cs = 8'(r) ^ 8'(c);
    txQ.push_back(8'hA5);
    txQ.push_back(8'(r));
    txQ.push_back(8'(c));
    for (int k = 0; k < r * c; k++) begin
      e = (presetQ.size() > 0) ? presetQ.pop_front() : 8'($urandom);
      txQ.push_back(e);
      cs ^= e;
      m[((k / c) * MAX_DIM + (k % c)) * 8 +: 8] = e;
    end
    if (corrupt) begin
      txQ.push_back(cs ^ 8'($urandom_range(1, 255)));
      expErr++;
      expCode = 2;
    end else begin
      txQ.push_back(cs);
      expMatrix = m;
      expRows   = r;
      expCols   = c;
      expCnt    = (expCnt + 1) % 256;
      expFv++;
    end
  endtask

  task automatic queueBadDim(input int r, input int c);
    txQ.push_back(8'hA5);
    txQ.push_back(8'(r));
    txQ.push_back(8'(c));
    expErr++;
    expCode = 1;
  endtask

  task automatic queueGarbage(input int n);
    logic [7:0] g;
    for (int k = 0; k < n; k++) begin
      g = 8'($urandom);
      if (g == 8'hA5) g = 8'h5A;
      txQ.push_back(g);
    end
  endtask

  task automatic checkState(input string tag);
    idleCycles(2);
    checkOutput({tag, "/fv"}, 256'(fvCount), 256'(expFv));
    checkOutput({tag, "/errs"}, 256'(errCount), 256'(expErr));
    checkOutput({tag, "/code"}, 256'(err_code), 256'(expCode));
    checkOutput({tag, "/rows"}, 256'(rows), 256'(expRows));
    checkOutput({tag, "/cols"}, 256'(cols), 256'(expCols));
    checkOutput({tag, "/cnt"}, 256'(frame_cnt), 256'(expCnt));
    checkOutput({tag, "/mat"}, 256'(matrix_flat), 256'(expMatrix));
    checkOutput({tag, "/snap"}, 256'(fvMatrix), 256'(expMatrix));
    checkOutput({tag, "/busy"}, 256'(busy), 256'(0));
  endtask

  task automatic resetModel();
    expMatrix = '0;
    expRows = 0; expCols = 0; expCnt = 0; expCode = 0;
    fvMatrix = '0;
  endtask

  initial begin
    int kind, r, c;
    rst = 1'b1; enable = 1'b1;
    byte_valid = 1'b0; byte_in = '0; byte_valid16 = 1'b0; byte_in16 = '0;
    expFv = 0; expErr = 0;
    resetModel();
    #12;
    checkOutput("rst/busy", 256'(busy), 256'(0));
    checkOutput("rst/fv", 256'(frame_valid), 256'(0));
    checkOutput("rst/err", 256'(err), 256'(0));
    checkOutput("rst/mat16", 256'(matrix16[255:0]), 256'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    checkState("reset");

    // Reference frame: 2x3 with a known checksum of 06.
    txQ = '{8'hA5, 8'h02, 8'h03, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h06};
    applyStimulus(0);
    expMatrix = '0;
    expMatrix[7:0] = 8'd1; expMatrix[15:8] = 8'd2; expMatrix[23:16] = 8'd3;
    expMatrix[47:40] = 8'd4; expMatrix[55:48] = 8'd5; expMatrix[63:56] = 8'd6;
    expRows = 2; expCols = 3; expCnt = 1; expFv = 1;
    checkState("frame2x3");

    txQ = '{8'h33, 8'hA5, 8'h06, 8'h02};
    applyStimulus(0);
    expErr = 1; expCode = 1;
    checkState("dimErr");

    txQ = '{8'hA5, 8'h02, 8'h03, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
    applyStimulus(1);
    expErr = 2; expCode = 2;
    checkState("csumErr");

    // Timeout: must not fire one cycle early, must fire on the last idle cycle.
    txQ = '{8'hA5, 8'h01};
    applyStimulus(0);
    checkOutput("toBusy", 256'(busy), 256'(1));
    idleCycles(TO - 1);
    checkOutput("toEarly", 256'(errCount), 256'(expErr));
    idleCycles(1);
    expErr++; expCode = 3;
    checkState("timeout");

    presetQ = '{8'h07};
    queueGood(1, 1, 1'b0);
    sendByte(txQ.pop_front());
    sendByte(txQ.pop_front());
    idleCycles(TO - 1);
    applyStimulus(0);
    checkState("byteWins");

    // enable low aborts silently and ignores bytes meanwhile.
    txQ = '{8'hA5, 8'h02, 8'h02};
    applyStimulus(0);
    enable = 1'b0;
    sendByte(8'hA5);
    checkOutput("enBusy", 256'(busy), 256'(0));
    enable = 1'b1;
    queueGood(2, 2, 1'b0);
    applyStimulus(0);
    checkState("enable");

    presetQ = '{8'hA5, 8'hA5};
    queueGood(1, 2, 1'b0);
    applyStimulus(0);
    checkState("a5Data");

    queueGood(3, 3, 1'b0);
    queueGood(5, 5, 1'b0);
    queueGood(1, 4, 1'b0);
    applyStimulus(0);
    checkState("backToBack");

    txQ = '{8'hA5, 8'h02, 8'h03, 8'h01};
    applyStimulus(0);
    #2 rst = 1'b1;
    #1;
    checkOutput("midRstBusy", 256'(busy), 256'(0));
    checkOutput("midRstMat", 256'(matrix_flat), 256'(0));
    #2 rst = 1'b0;
    idleCycles(1);
    resetModel();
    checkState("midReset");
    txQ = '{8'hA5, 8'h01, 8'h01, 8'h09, 8'h09};
    applyStimulus(0);
    expMatrix = '0; expMatrix[7:0] = 8'h09;
    expRows = 1; expCols = 1; expCnt = 1; expFv++;
    checkState("after rst");

    for (int it = 0; it < 40; it++) begin
      queueGarbage($urandom_range(0, 2));
      kind = $urandom_range(0, 9);
      r = $urandom_range(1, MAX_DIM);
      c = $urandom_range(1, MAX_DIM);
      if (kind <= 5) begin
        queueGood(r, c, 1'b0);
      end else if (kind <= 7) begin
        queueGood(r, c, 1'b1);
      end else if (kind == 8) begin
        if ($urandom_range(0, 1) == 1) queueBadDim($urandom_range(0, 1) ? 0 : $urandom_range(MAX_DIM + 1, 255), c);
        else                           queueBadDim(r, $urandom_range(0, 1) ? 0 : $urandom_range(MAX_DIM + 1, 255));
      end else begin
        queueGood(r, c, 1'b0);
        queueGood(c, r, 1'b0);
      end
      applyStimulus(2);
      checkState("random");
    end

    // 16-bit elements: 1x1 then 2x1 frames.
    foreach (txQ[i]) txQ.delete(i);
    sendByte16(8'hA5); sendByte16(8'h01); sendByte16(8'h01);
    sendByte16(8'h12); sendByte16(8'h34); sendByte16(8'h26);
    idleCycles(1);
    checkOutput("w16/e0", 256'(matrix16[15:0]), 256'(16'h1234));
    checkOutput("w16/cnt", 256'(frame_cnt16), 256'(1));
    sendByte16(8'hA5); sendByte16(8'h02); sendByte16(8'h01);
    sendByte16(8'hAB); sendByte16(8'hCD); sendByte16(8'h00); sendByte16(8'h5A);
    sendByte16(8'h3F);
    idleCycles(1);
    checkOutput("w16/r1e0", 256'(matrix16[15:0]), 256'(16'hABCD));
    checkOutput("w16/r2e0", 256'(matrix16[95:80]), 256'(16'h005A));
    checkOutput("w16/rows", 256'(rows16), 256'(2));
    checkOutput("w16/err", 256'(err_code16), 256'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/matrix_frame_rx.md
MATRIX_FRAME_RX -- requirements
Module: matrix_frame_rx

Interface
REQ-001 SHALL have parameter MAX_DIM, default 5; maximum rows and cols, legal range 1..7.
REQ-002 SHALL have parameter ELEM_W, default 8; element width in bits, legal values 8 or 16; EB = ELEM_W/8 bytes per element.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 50000; idle cycles allowed between bytes inside a frame.
REQ-004 SHALL have port clk, input, 1 bit; the single clock, rising-edge active.
REQ-005 SHALL have port rst, input, 1 bit; reset, asynchronous and active-high.
REQ-006 SHALL have port enable, input, 1 bit; parser enable.
REQ-007 SHALL have port byte_in, input, 8 bits; received byte.
REQ-008 SHALL have port byte_valid, input, 1 bit; single-cycle strobe qualifying byte_in.
REQ-009 SHALL have port rows, output, 3 bits; row count of the last good frame.
REQ-010 SHALL have port cols, output, 3 bits; column count of the last good frame.
REQ-011 SHALL have port matrix_flat, output, MAX_DIM*MAX_DIM*ELEM_W bits; element (r,c) at index i=r*MAX_DIM+c, occupying bits [(i+1)*ELEM_W-1 : i*ELEM_W].
REQ-012 SHALL have port frame_valid, output, 1 bit; one-cycle pulse on each good frame.
REQ-013 SHALL have port busy, output, 1 bit; high in every state except IDLE.
REQ-014 SHALL have port err, output, 1 bit; one-cycle error pulse.
REQ-015 SHALL have port err_code, output, 2 bits; 1 = dimension, 2 = checksum, 3 = timeout; holds until the next err pulse.
REQ-016 SHALL have port frame_cnt, output, 8 bits; count of good frames, wraps 255->0.

Function
REQ-017 Frame format SHALL be: 0xA5, rows, cols, rows*cols elements row-major with EB bytes each MSB-first, then a checksum byte equal to the XOR of every byte after 0xA5.
REQ-018 FSM states SHALL be IDLE, ROWS, COLS, DATA, CSUM; a byte is consumed only on a cycle where byte_valid=1.
REQ-019 In IDLE, 0xA5 SHALL go to ROWS; any other byte SHALL be ignored.
REQ-020 ROWS SHALL latch the row count and go to COLS; COLS SHALL latch the column count and check both dimensions.
REQ-021 If either dimension is 0 or >MAX_DIM, SHALL pulse err with err_code=1 and go to IDLE; otherwise SHALL go to DATA.
REQ-022 DATA SHALL assemble elements into a shadow buffer using an element counter and a byte counter, and go to CSUM after the last byte of element rows*cols-1.
REQ-023 In CSUM, on a match the shadow buffer SHALL be copied to matrix_flat, rows/cols updated, frame_cnt incremented and frame_valid pulsed; the FSM SHALL return to IDLE.
REQ-024 frame_valid SHALL be high in the cycle after the edge that samples the checksum byte, with matrix_flat, rows and cols already updated in that cycle.
REQ-025 On a checksum mismatch, SHALL pulse err with err_code=2, leave outputs unchanged and go to IDLE.
REQ-026 Shadow entries at indices >= rows*cols SHALL be zeroed at the start of each frame so that unused elements of matrix_flat read 0.
REQ-027 The timeout counter SHALL clear on every byte_valid and on entry to IDLE, and increment otherwise while busy.
REQ-028 When the timeout counter reaches TIMEOUT_CYC-1 with no byte, SHALL pulse err with err_code=3 and go to IDLE.
REQ-029 If a byte arrives in the same cycle as timeout expiry, the byte SHALL win: it is consumed and no timeout occurs.
REQ-030 enable=0 SHALL force IDLE on the next edge without raising err; bytes are ignored while enable=0.
REQ-031 A 0xA5 arriving mid-frame SHALL be treated as data, not as a resynchronisation.
REQ-032 Back-to-back frames with zero gap SHALL be accepted: the byte following the checksum byte is processed in IDLE.

Reset
REQ-033 On rst=1 the FSM SHALL go to IDLE immediately (asynchronously) and all counters SHALL clear.
REQ-034 On rst=1 rows, cols, matrix_flat, frame_cnt and err_code SHALL be 0, and frame_valid, err and busy SHALL be 0.
REQ-035 A reset mid-frame SHALL discard the partial frame and produce no pulse.

Verification (MAX_DIM=5, ELEM_W=8, TIMEOUT_CYC=100)
REQ-036 Bytes A5 02 03 01 02 03 04 05 06 06 -> frame_valid pulse; rows=2, cols=3; elements 0..2=1,2,3, elements 5..7=4,5,6, all others 0; frame_cnt=1.
REQ-037 Bytes 33 A5 06 02 -> err pulse with err_code=1; busy=0 afterwards; no frame_valid.
REQ-038 Same frame as REQ-036 with checksum 07 -> err_code=2; matrix_flat keeps its prior value.
REQ-039 A5 01 followed by 100 idle cycles -> err_code=3, busy=0; then a byte strobe in the expiry cycle of a repeat run -> no error.
REQ-040 rst asserted after A5 02 03 01, then a full 1x1 frame A5 01 01 09 09 -> rows=1, cols=1, element 0=9, frame_cnt=1.
REQ-041 ELEM_W=16: A5 01 01 12 34 26 -> element 0=0x1234.
